// File: rtl/npu_act_mem_arb_if.sv
// Bus bundle for the activation-memory write arbiter and the RGB/activation read-data mux.
interface npu_act_mem_arb_if #(
  parameter int NUM_CH = 32,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        hw_mem_wr;
  logic [NUM_CH*ADDR_W-1:0] hw_mem_wr_addr;
  logic [NUM_CH*DATA_W-1:0] hw_mem_wr_data;
  logic [NUM_CH-1:0]        hw_mem_wr_ack_p;
  logic                     wr_stall;
  logic                     npu_act_mem_wr_en;
  logic [ADDR_W-1:0]        npu_act_mem_wr_addr;
  logic [DATA_W-1:0]        npu_act_mem_wr_data;
  logic [IDX_W-1:0]         grant_idx;
  logic                     hw_rgb_mem_rd;
  logic                     hw_act_mem_rd;
  logic                     hw_act_mem_rd_bypass;
  logic [DATA_W-1:0]        npu_rgb_rddata;
  logic [DATA_W-1:0]        npu_act_mem_rd_data;
  logic [DATA_W-1:0]        npu_muxed_rgb_act_mem_rd_data;
  logic                     npu_muxed_rd_valid;

  modport slave (
    input  hw_mem_wr, hw_mem_wr_addr, hw_mem_wr_data, wr_stall,
           hw_rgb_mem_rd, hw_act_mem_rd, hw_act_mem_rd_bypass,
           npu_rgb_rddata, npu_act_mem_rd_data,
    output hw_mem_wr_ack_p, npu_act_mem_wr_en, npu_act_mem_wr_addr,
           npu_act_mem_wr_data, grant_idx,
           npu_muxed_rgb_act_mem_rd_data, npu_muxed_rd_valid
  );

  modport master (
    output hw_mem_wr, hw_mem_wr_addr, hw_mem_wr_data, wr_stall,
           hw_rgb_mem_rd, hw_act_mem_rd, hw_act_mem_rd_bypass,
           npu_rgb_rddata, npu_act_mem_rd_data,
    input  hw_mem_wr_ack_p, npu_act_mem_wr_en, npu_act_mem_wr_addr,
           npu_act_mem_wr_data, grant_idx,
           npu_muxed_rgb_act_mem_rd_data, npu_muxed_rd_valid
  );
endinterface

// File: rtl/npu_act_mem_arb.sv
// Round-robin write arbiter into the activation memory, plus a latency-aligned
// read-data mux selecting pad-zero / RGB / activation read data.
module npu_act_mem_arb #(
  parameter int NUM_CH = 32,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input logic              clk,
  input logic              resetn,
  npu_act_mem_arb_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CH);

  typedef struct packed {
    logic byp;
    logic rgb;
    logic act;
  } rd_req_t;

  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_data;
  logic [IDX_W-1:0]              gidx_q, win;
  logic                          found, grant;
  logic                          wr_en_q;
  logic [ADDR_W-1:0]             wr_addr_q;
  logic [DATA_W-1:0]             wr_data_q;

  assign ch_addr = bus.hw_mem_wr_addr;
  assign ch_data = bus.hw_mem_wr_data;

  // Visit only requesting channels, starting just after the last winner.
  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    win   = gidx_q;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (int'(gidx_q) + k) % NUM_CH;
      if (!found && bus.hw_mem_wr[IDX_W'(c)]) begin
        found = 1'b1;
        win   = IDX_W'(c);
      end
    end
  end

  assign grant = found && !bus.wr_stall && resetn;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ack
    assign bus.hw_mem_wr_ack_p[i] = grant && (win == IDX_W'(i));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      gidx_q    <= IDX_W'(NUM_CH - 1);
    end else begin
      wr_en_q <= grant;
      if (grant) begin
        wr_addr_q <= ch_addr[win];
        wr_data_q <= ch_data[win];
        gidx_q    <= win;
      end
    end
  end

  assign bus.npu_act_mem_wr_en   = wr_en_q;
  assign bus.npu_act_mem_wr_addr = wr_addr_q;
  assign bus.npu_act_mem_wr_data = wr_data_q;
  assign bus.grant_idx           = gidx_q;

  // Read control rides a RD_LAT-deep pipe so it meets its data at stage RD_LAT.
  rd_req_t                 rd_in, rd_al;
  rd_req_t [RD_LAT:1]      vld_pipe;
  logic                    rd_any;
  logic [DATA_W-1:0]       rd_sel, rd_data_q;
  logic                    rd_vld_q;

  assign rd_in = '{byp: bus.hw_act_mem_rd_bypass, rgb: bus.hw_rgb_mem_rd,
                   act: bus.hw_act_mem_rd};
  assign rd_al  = vld_pipe[RD_LAT];
  assign rd_any = rd_al.byp | rd_al.rgb | rd_al.act;

  always_comb begin
    rd_sel = bus.npu_act_mem_rd_data;
    if (rd_al.byp)      rd_sel = '0;
    else if (rd_al.rgb) rd_sel = bus.npu_rgb_rddata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe  <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      vld_pipe[1] <= rd_in;
      for (int s = 2; s <= RD_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
      rd_vld_q <= rd_any;
      if (rd_any) rd_data_q <= rd_sel;
    end
  end

  assign bus.npu_muxed_rgb_act_mem_rd_data = rd_data_q;
  assign bus.npu_muxed_rd_valid            = rd_vld_q;
endmodule

// File: doc/npu_act_mem_arb.md
NPU_ACT_MEM_ARB -- requirements
Module: npu_act_mem_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 32: number of write requesters, 2..64.
REQ-002 SHALL have parameter ADDR_W, default 14: activation memory address width.
REQ-003 SHALL have parameter DATA_W, default 8: pixel and activation data width.
REQ-004 SHALL have parameter RD_LAT, default 1: read latency of the RGB and activation memories, 1..3 cycles.
REQ-005 SHALL have port clk  in  1  sole clock; all logic samples on its rising edge.
REQ-006 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port hw_mem_wr  in  NUM_CH  per-channel write request; a channel holds it level until that channel's ack.
REQ-008 SHALL have port hw_mem_wr_addr  in  NUM_CH*ADDR_W  packed addresses; channel i uses bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port hw_mem_wr_data  in  NUM_CH*DATA_W  packed data; channel i uses bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port hw_mem_wr_ack_p  out  NUM_CH  one-hot grant pulse, combinational.
REQ-011 SHALL have port wr_stall  in  1  memory busy; when high, no grant is issued.
REQ-012 SHALL have port npu_act_mem_wr_en  out  1  registered write strobe.
REQ-013 SHALL have port npu_act_mem_wr_addr  out  ADDR_W  registered write address.
REQ-014 SHALL have port npu_act_mem_wr_data  out  DATA_W  registered write data.
REQ-015 SHALL have port grant_idx  out  $clog2(NUM_CH)  index of the last granted channel (registered).
REQ-016 SHALL have port hw_rgb_mem_rd  in  1  read issued to the RGB memory this cycle.
REQ-017 SHALL have port hw_act_mem_rd  in  1  read issued to the activation memory this cycle.
REQ-018 SHALL have port hw_act_mem_rd_bypass  in  1  pad read; the returned data is forced to zero.
REQ-019 SHALL have port npu_rgb_rddata  in  DATA_W  RGB memory read data.
REQ-020 SHALL have port npu_act_mem_rd_data  in  DATA_W  activation memory read data.
REQ-021 SHALL have port npu_muxed_rgb_act_mem_rd_data  out  DATA_W  registered muxed read data.
REQ-022 SHALL have port npu_muxed_rd_valid  out  1  single-cycle qualifier for the muxed read data.

Function
REQ-023 Write arbitration SHALL be round-robin.
- Search starts at index (grant_idx+1) mod NUM_CH and wraps.
- The first channel found with hw_mem_wr high is granted.
- Only requesting channels are visited; no idle slots are spent on non-requesting channels.
REQ-024 At most one bit of hw_mem_wr_ack_p SHALL be high in any cycle.
- Ack is high for channel i in the cycle it is granted.
- Ack is gated off when wr_stall=1 or resetn=0.
REQ-025 On a grant of channel i at cycle N, the outputs at cycle N+1 SHALL be: wr_en=1, wr_addr = channel i's address, wr_data = channel i's data, grant_idx = i.
REQ-026 In cycles with no grant, wr_en SHALL be 0 and wr_addr, wr_data and grant_idx SHALL hold their values.
REQ-027 If a channel still has hw_mem_wr high in the cycle after its ack, that SHALL be treated as a new request; fairness is preserved through the pointer.
REQ-028 With K channels requesting continuously, each SHALL be granted exactly once in every K consecutive grants.
REQ-029 A pending request SHALL be granted within NUM_CH unstalled cycles.
REQ-030 Read path control SHALL be delayed RD_LAT cycles to align with the memory data, then registered once more; data and valid therefore appear RD_LAT+1 cycles after the request.
REQ-031 Read data select priority:
- bypass=1 gives 0.
- else rgb_rd=1 gives npu_rgb_rddata.
- else act_rd=1 gives npu_act_mem_rd_data.
- npu_muxed_rd_valid = rgb_rd | act_rd | bypass of the aligned request.
REQ-032 When valid is 0, the muxed data SHALL hold its previous value.
REQ-033 Back-to-back reads SHALL be accepted one per cycle with no bubbles.

Reset
REQ-034 While resetn=0, asynchronously:
- wr_en=0, wr_addr=0, wr_data=0.
- grant_idx = NUM_CH-1, so the first grant after reset searches from channel 0.
- muxed data = 0, valid = 0.
- all read-delay stages cleared; all acks 0.
REQ-035 Reset asserted mid-operation SHALL discard in-flight writes and reads; no write strobe or valid is issued for them after release.

Verification
REQ-036 Reset release, hw_mem_wr=0x5 (channels 0 and 2), addr0=0x10, data0=0xAA, addr2=0x20, data2=0xBB:
- ack[0] at cycle 0, ack[2] at cycle 1.
- Memory writes (0x10,0xAA) then (0x20,0xBB) on consecutive cycles; no idle cycle between them.
REQ-037 All 32 channels held high for 64 cycles: acks in the order 0..31,0..31 with exactly one per cycle; wr_en high for all 64 cycles.
REQ-038 Channels 3 and 5 requesting, wr_stall=1 for 4 cycles then 0:
- no ack and wr_en=0 during the stall.
- ack[3], then ack[5], on the first two unstalled cycles.
REQ-039 RD_LAT=2, with hw_act_mem_rd_bypass=1, hw_rgb_mem_rd=1, rgb data 0x7F all in the same cycle: after 3 cycles, valid=1 and data=0x00. Next, hw_rgb_mem_rd=1 alone gives 0x7F.
REQ-040 resetn pulsed low while channel 7 is acked: wr_en stays 0 after release, and grant_idx = NUM_CH-1.
REQ-041 NUM_CH=4: channel 3 granted, then channels 0 and 3 requesting: channel 0 is granted first (wrap-around).
